mix_word_packer: RTL and testbench
==================================

// Module: mix_word_packer
// PURPOSE
//  Upstream feeder for the 64-bit xor/add/mul/rotate mixing stage.
//  - Accepts a byte stream (valid/ready, per-byte last flag).
//  - Packs every 8 bytes into one 64-bit word: the x operand of the mixer.
//  - Pads a short final word and tags it with last and valid-byte count.
//  - Double-buffered: byte stream runs at 1 byte/clk while the mixer side stalls.
// PARAMETERS
//  PAD_BYTE   8'h00   fill value for unused byte lanes of a short final word
// PORTS
//  clk          in   1   sole clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  in_valid     in   1   byte on in_data is valid
//  in_ready     out  1   packer accepts byte this cycle
//  in_data      in   8   input byte
//  in_last      in   1   this byte ends the message
//  out_valid    out  1   out_data/out_last/out_nbytes valid
//  out_ready    in   1   mixer consumes word this cycle
//  out_data     out  64  packed word (mixer input x)
//  out_last     out  1   word holds the final byte of the message
//  out_nbytes   out  4   real bytes in word, 1..8
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_last=0, out_nbytes=0, in_ready=0 during rst.
//    Internally: idx=0, acc=0, state=FILL. In-flight partial and buffered words are dropped.
//    in_ready=1 from the first cycle after rst deasserts.
//  - Byte transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
//  - Storage:
//    - acc[63:0]: assembly register.
//    - idx[2:0]: next byte lane.
//    - out register: holds one word.
//  - Lane order: byte k of the word goes to bits [8k+7:8k] (little-endian).
//    The first byte of the word is in out_data[7:0].
//  - FSM: FILL, FULL.
//    - FILL: in_ready=1. Each byte is written to lane idx.
//      - Word completes when idx==7 or in_last=1.
//      - On completion, with the out register free (!out_valid | out_ready) in the same cycle:
//        load the out register, set idx=0, stay in FILL.
//        The word is registered and appears 1 clk after the completing byte.
//      - On completion with the out register busy: hold the word in acc, go to FULL.
//      - No completion: idx++.
//    - FULL: in_ready=0. When out_ready=1, the out register reloads from acc,
//      idx=0, and the FSM returns to FILL. Byte acceptance resumes the next cycle.
//  - Short word (in_last with idx<7): lanes idx+1..7 are filled with PAD_BYTE.
//    out_nbytes=idx+1 and out_last=1.
//  - in_last at idx==7: out_nbytes=8, out_last=1. No extra empty word is emitted.
//  - Zero-length messages are impossible: last is always attached to a real byte.
//  - out_valid stays high and out_data/out_last/out_nbytes stay stable until the output transfer.
//  - out_valid clears on transfer unless a new word loads in the same cycle (back-to-back allowed).
//  - in_last only matters on a byte transfer. The next byte starts a new message at lane 0.
//  - in_ready never depends combinationally on in_valid or in_data.
// CONFIGURATION
//  MIX_PACK_BSWAP_EN defined:
//    - Big-endian lane order: byte k goes to bits [63-8k:56-8k].
//    - A short word keeps real bytes in the high lanes and PAD_BYTE in the low lanes.
//  MIX_PACK_BSWAP_EN undefined: little-endian as above. No other behaviour changes.
// TESTING
//  1) 01..08, no last, out_ready=1 -> out_data=64'h0807060504030201, nbytes=8, last=0, 1 clk after byte 08.
//  2) AA,BB,CC with last on CC, PAD_BYTE=00 -> out_data=64'h0000000000CCBBAA, nbytes=3, last=1.
//  3) MIX_PACK_BSWAP_EN, 01..08 -> out_data=64'h0102030405060708.
//     Same define with AA,BB,CC+last -> 64'hAABBCC0000000000.
//  4) out_ready=0, 16 bytes streamed at full rate:
//     - in_ready=1 through byte 16, then 0.
//     - Raise out_ready -> words 0x..01 and 0x..09 each delivered once, in order.
//     - in_ready returns 1 the cycle after the second load.
//  5) 5 bytes, then rst for 1 clk, then 11..18 -> no stale word;
//     single out_data=64'h1817161514131211.
//  6) last on 8th byte, then 9th byte with last -> two words, nbytes 8/1, both last=1;
//     second word = 64'h00000000000000XX.

Source files
------------

// File: rtl/mix_word_packer_if.sv
// Byte-in / word-out handshake bundle for mix_word_packer.
// slave = packer side, master = byte source plus mixer sink.
interface mix_word_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic [3:0]  out_nbytes;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_nbytes
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_nbytes
    );
endinterface

// File: rtl/mix_word_packer.sv
// Packs a byte stream into 64-bit mixer words; short final words padded with PAD_BYTE. MIX_PACK_BSWAP_EN selects big-endian lanes.
// Latency: word registered 1 clk after its completing byte.
// Backpressure: acc holds one completed word while the out register is stalled; in_ready drops only then.
module mix_word_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    mix_word_packer_if.slave bus
);

    typedef enum logic {FILL, FULL} state_t;

    state_t      state_q, state_d;
    logic [63:0] acc;
    logic [2:0]  idx;
    logic        hold_last;
    logic [3:0]  hold_nbytes;

    logic [63:0] out_data_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic [3:0]  out_nbytes_q;

    logic [63:0] word;
    logic [3:0]  nbytes;
    logic        in_ready_i;
    logic        byte_xfer;
    logic        complete;
    logic        out_free;
    logic        load_new;
    logic        load_held;

    function automatic logic [5:0] lane_lsb(input logic [2:0] k);
`ifdef MIX_PACK_BSWAP_EN
        return {3'd7 - k, 3'b000};
`else
        return {k, 3'b000};
`endif
    endfunction

    // Lanes above idx only matter when this byte ends the message; then they take the pad.
    always_comb begin
        word = acc;
        for (int k = 0; k < 8; k++) begin
            if (3'(k) == idx)
                word[lane_lsb(3'(k)) +: 8] = bus.in_data;
            else if (3'(k) > idx && bus.in_last)
                word[lane_lsb(3'(k)) +: 8] = PAD_BYTE;
        end
    end

    assign nbytes    = {1'b0, idx} + 4'd1;
    assign byte_xfer = bus.in_valid & in_ready_i;
    assign complete  = byte_xfer & ((idx == 3'd7) | bus.in_last);
    assign out_free  = ~out_valid_q | bus.out_ready;

    always_comb begin
        state_d    = state_q;
        in_ready_i = 1'b0;
        load_new   = 1'b0;
        load_held  = 1'b0;
        case (state_q)
            FILL: begin
                in_ready_i = ~rst;
                load_new   = complete & out_free;
                if (complete && !out_free)
                    state_d = FULL;
            end
            FULL: begin
                if (bus.out_ready) begin
                    load_held = 1'b1;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            acc          <= 64'd0;
            idx          <= 3'd0;
            hold_last    <= 1'b0;
            hold_nbytes  <= 4'd0;
            out_data_q   <= 64'd0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_nbytes_q <= 4'd0;
        end else begin
            state_q <= state_d;

            if (out_valid_q && bus.out_ready)
                out_valid_q <= 1'b0;

            if (load_new) begin
                out_data_q   <= word;
                out_last_q   <= bus.in_last;
                out_nbytes_q <= nbytes;
                out_valid_q  <= 1'b1;
            end else if (load_held) begin
                out_data_q   <= acc;
                out_last_q   <= hold_last;
                out_nbytes_q <= hold_nbytes;
                out_valid_q  <= 1'b1;
            end

            // A completed word parks in acc; it is only read back if the out register was busy.
            if (byte_xfer) begin
                acc <= word;
                if (complete) begin
                    idx         <= 3'd0;
                    hold_last   <= bus.in_last;
                    hold_nbytes <= nbytes;
                end else begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready_i;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_nbytes = out_nbytes_q;

endmodule

// File: tb/tb_mix_word_packer.sv
// Scoreboard bench for mix_word_packer: a byte-level model pushes expected words, a negedge monitor pops them.
module tb_mix_word_packer;

    localparam logic [7:0] PAD = 8'h00;

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [3:0]  n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mix_word_packer_if bus ();

    mix_word_packer #(.PAD_BYTE(PAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rx  = 0;
    exp_t sb[$];
    logic [7:0] mbytes[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    function automatic int lane_pos(input int k);
`ifdef MIX_PACK_BSWAP_EN
        return 56 - 8 * k;
`else
        return 8 * k;
`endif
    endfunction

    task automatic model_push(input logic [7:0] d, input logic l);
        exp_t e;
        mbytes.push_back(d);
        if (l || mbytes.size() == 8) begin
            e.d = {8{PAD}};
            for (int k = 0; k < mbytes.size(); k++)
                e.d[lane_pos(k) +: 8] = mbytes[k];
            e.l = l;
            e.n = 4'(mbytes.size());
            sb.push_back(e);
            mbytes.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte transferred.
    task automatic send(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(posedge clk);
            #1 bus.out_ready = 1'b1;
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 64'(bus.in_ready), 64'd1);
            @(posedge clk);
        end else begin
            @(posedge clk);
            model_push(d, l);
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("rst_out_data",   bus.out_data,        64'd0);
        chk("rst_out_last",   64'(bus.out_last),   64'd0);
        chk("rst_out_nbytes", 64'(bus.out_nbytes), 64'd0);
        chk("rst_in_ready",   64'(bus.in_ready),   64'd0);
        mbytes.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_rx++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data",   bus.out_data,        e.d);
                chk("out_last",   64'(bus.out_last),   64'(e.l));
                chk("out_nbytes", 64'(bus.out_nbytes), 64'(e.n));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0;
        logic [63:0] c1, c2;
`ifdef MIX_PACK_BSWAP_EN
        c1 = 64'h0102030405060708;
        c2 = 64'hAABBCC0000000000;
`else
        c1 = 64'h0807060504030201;
        c2 = 64'h0000000000CCBBAA;
`endif
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        do_reset();

        // 1) full word, one clock after the 8th byte
        for (int i = 1; i <= 7; i++) send(8'(i), 1'b0);
        @(negedge clk);
        chk("t1_not_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(8'h08, 1'b0);
        @(negedge clk);
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_data",  bus.out_data,       c1);
        @(posedge clk);
        #1;
        drain("t1_drain");

        // 2) short padded word
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        @(negedge clk);
        chk("t2_data",   bus.out_data,        c2);
        chk("t2_nbytes", 64'(bus.out_nbytes), 64'd3);
        @(posedge clk);
        #1;
        drain("t2_drain");

        // 4) stalled mixer, 16 bytes at full rate
        bus.out_ready = 1'b0;
        rx0 = n_rx;
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
        @(negedge clk);
        chk("t4_full_rdy", 64'(bus.in_ready), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_hold_rdy", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_rdy_back", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        drain("t4_drain");
        chk("t4_words", 64'(n_rx - rx0), 64'd2);

        // 5) reset drops a partial word
        for (int i = 1; i <= 5; i++) send(8'(8'hE0 + i), 1'b0);
        do_reset();
        rx0 = n_rx;
        for (int i = 1; i <= 8; i++) send(8'(8'h10 + i), 1'b0);
        drain("t5_drain");
        chk("t5_words", 64'(n_rx - rx0), 64'd1);

        // 6) last on byte 8, then a one-byte message
        rx0 = n_rx;
        for (int i = 1; i <= 8; i++) send(8'(8'h20 + i), i == 8);
        send(8'h5A, 1'b1);
        drain("t6_drain");
        chk("t6_words", 64'(n_rx - rx0), 64'd2);

        // random bytes, random lasts, random mixer stalls
        for (int i = 0; i < 60; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            send(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
        end
        send(8'h77, 1'b1);
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
